mem_bridge: RTL
===============

// Module: mem_bridge
// PURPOSE
//  Responder side of the control unit's memory strobes (MemRead/MemWrite, IorD-muxed address).
//  Serves each 16-bit word request over an 8-bit synchronous SRAM port as two byte beats.
//  Pulses MemReady when the word is done; the control FSM holds its Lw/Sw state until then.
//  Sits between the control/datapath address mux and the physical memory.
// PARAMETERS
//  ADDR_W       16  word address width
//  DATA_W       16  word width; must be 2*8
//  WAIT_CYCLES  1   extra SRAM cycles per byte beat (0..15)
// PORTS
//  CLK         in   1         clock, all logic on posedge
//  Reset       in   1         synchronous, active-high
//  MemRead     in   1         read request; held by initiator until MemReady
//  MemWrite    in   1         write request; held by initiator until MemReady
//  Addr        in   ADDR_W    word address (PC or ALUOut per IorD)
//  WrData      in   DATA_W    store data
//  RdData      out  DATA_W    read word; registered, held until next read completes
//  MemReady    out  1         one-cycle completion pulse
//  Busy        out  1         high in any state except IDLE
//  sram_addr   out  ADDR_W+1  byte address {Addr,beat}
//  sram_wdata  out  8         byte write data
//  sram_rdata  in   8         byte read data, valid the cycle after sram_oe with a stable address
//  sram_we     out  1         byte write enable
//  sram_oe     out  1         byte output enable
// BEHAVIOUR
//  Reset: state=IDLE. RdData=0, MemReady=0, Busy=0, sram_we=0, sram_oe=0, sram_addr=0,
//    sram_wdata=0, wait count=0.
//  Reset mid-transaction aborts at once: no further SRAM strobes. A partially written word
//    stays partial. No MemReady is issued.
//  States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
//  IDLE samples the request each edge.
//    MemWrite=1: latch Addr and WrData, go to WR_LO. Write wins if both strobes are high.
//    MemRead=1 only: latch Addr, go to RD_LO.
//    Neither: stay in IDLE.
//  Each beat state lasts WAIT_CYCLES+1 cycles, timed by the wait counter.
//    The counter reloads on state entry; the state exits when the count is 0.
//  RD_LO / RD_HI:
//    sram_oe=1; sram_addr={A,0} for LO, {A,1} for HI.
//    sram_rdata is captured on the last cycle of the beat: LO -> RdData[7:0], HI -> RdData[15:8].
//    The RdData update is visible when MemReady rises.
//  WR_LO / WR_HI:
//    sram_we=1 for every cycle of the beat; sram_wdata = D[7:0] (LO) or D[15:8] (HI).
//    Address and data stay stable for the whole beat.
//  Byte order is little-endian: low byte at the even byte address.
//  DONE: MemReady=1 for exactly 1 cycle, then IDLE. Strobes are ignored in DONE.
//    The control FSM advances on the same edge, so no request is duplicated.
//  Latency: MemReady is high in cycle 2*(WAIT_CYCLES+1)+1 after the accepting edge
//    (5 for WAIT_CYCLES=1).
//  Input changes: Addr/WrData changes after acceptance are ignored, because the values are latched.
//    A strobe dropped before MemReady does not cancel the transaction.
//  Wrap: Addr=all-ones uses byte addresses 2^(ADDR_W+1)-2 and -1. No wrap into the next word.
//  Outputs are Moore-decoded from the state plus registers only; there are no comb paths from
//    inputs to outputs.
// STRUCTURE
//  Shared package: state encoding constants, BYTE_W=8, the WAIT_CYCLES range check.
//  Sub-module mem_wait_counter: 4-bit loadable down-counter with load/en/zero ports,
//    reused by later peripheral blocks.
//  Top: state register, next-state logic, address/data latches, RdData assembly register.
// TESTING
//  Reset, then MemRead with Addr=0x0010 and SRAM model [0x20]=0x34, [0x21]=0x12
//    -> RdData=0x1234 and MemReady pulses in cycle 5 (W=1).
//  MemWrite with Addr=0x0003, WrData=0xBEEF
//    -> sram_we high for 2 cycles at 0x06 with 0xEF, then 2 cycles at 0x07 with 0xBE;
//       one MemReady; SRAM reads back 0xBEEF.
//  MemRead=MemWrite=1 together, Addr=5, WrData=0xA5A5 -> write path taken, no sram_oe.
//  Reset asserted in cycle 3 of a write -> next cycle: IDLE, sram_we=0, RdData=0, no MemReady.
//  WAIT_CYCLES=0, back-to-back Lw then Sw from the control FSM
//    -> each completes in 3 cycles, IDLE for exactly 1 cycle between them.
//  Addr=0xFFFF read -> byte addresses 0x1FFFE and 0x1FFFF, correct word; Addr change after
//    acceptance has no effect.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the memory bridge: FSM encoding, byte width and
// the wait-cycle range check.
package mem_bridge_pkg;

  localparam int BYTE_W   = 8;
  localparam int WAIT_W   = 4;
  localparam int WAIT_MAX = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic bit wait_cycles_ok(input int w);
    return (w >= 0) && (w <= WAIT_MAX);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times SRAM beats; zero flags the last cycle
// of a beat.
module mem_wait_counter
  import mem_bridge_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic              load,
  input  logic              en,
  input  logic [WAIT_W-1:0] load_value,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  // NOTE: sequential state is only ever assigned with <= so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_bridge.sv
// Serves 16-bit word requests from the control FSM as two little-endian
// byte beats on an 8-bit synchronous SRAM, pulsing MemReady on completion.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              MemReady,
  output logic              Busy,
  output logic [ADDR_W:0]   sram_addr,
  output logic [BYTE_W-1:0] sram_wdata,
  input  logic [BYTE_W-1:0] sram_rdata,
  output logic              sram_we,
  output logic              sram_oe
);

  if (!wait_cycles_ok(WAIT_CYCLES) || (DATA_W != 2 * BYTE_W)) begin : g_bad_param
    $error("mem_bridge: WAIT_CYCLES must be 0..15 and DATA_W must be 16");
  end

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [BYTE_W-1:0]   data_hi_q;
  logic [BYTE_W-1:0]   rd_lo_q;
  logic                beat;
  logic                cnt_zero;

  assign beat = (state == RD_LO) || (state == RD_HI) ||
                (state == WR_LO) || (state == WR_HI);

  // Reloading whenever no beat is running guarantees a full count on entry.
  mem_wait_counter u_wait (
    .CLK        (CLK),
    .Reset      (Reset),
    .load       (!beat || cnt_zero),
    .en         (beat),
    .load_value (WAIT_W'(WAIT_CYCLES)),
    .zero       (cnt_zero)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_hi_q  <= '0;
      rd_lo_q    <= '0;
      RdData     <= '0;
      MemReady   <= 1'b0;
      Busy       <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      sram_oe    <= 1'b0;
    end else begin
      MemReady <= 1'b0;
      case (state)
        IDLE: begin
          if (MemWrite) begin
            addr_q     <= Addr;
            data_hi_q  <= WrData[DATA_W-1:BYTE_W];
            sram_addr  <= {Addr, 1'b0};
            sram_wdata <= WrData[BYTE_W-1:0];
            sram_we    <= 1'b1;
            Busy       <= 1'b1;
            state      <= WR_LO;
          end else if (MemRead) begin
            addr_q    <= Addr;
            sram_addr <= {Addr, 1'b0};
            sram_oe   <= 1'b1;
            Busy      <= 1'b1;
            state     <= RD_LO;
          end
        end
        RD_LO: begin
          if (cnt_zero) begin
            rd_lo_q   <= sram_rdata;
            sram_addr <= {addr_q, 1'b1};
            state     <= RD_HI;
          end
        end
        RD_HI: begin
          // Both bytes land together so RdData only changes on completion.
          if (cnt_zero) begin
            RdData   <= {sram_rdata, rd_lo_q};
            sram_oe  <= 1'b0;
            MemReady <= 1'b1;
            state    <= DONE;
          end
        end
        WR_LO: begin
          if (cnt_zero) begin
            sram_addr  <= {addr_q, 1'b1};
            sram_wdata <= data_hi_q;
            state      <= WR_HI;
          end
        end
        WR_HI: begin
          if (cnt_zero) begin
            sram_we  <= 1'b0;
            MemReady <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          sram_we <= 1'b0;
          sram_oe <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
